// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot and run-control sequencer.
package boot_seq_pkg;

    localparam int FLL_ADDR_W = 2;

    typedef enum logic [2:0] {
        ST_CFG_REQ    = 3'd0,
        ST_CFG_NEXT   = 3'd1,
        ST_LOCK_WAIT  = 3'd2,
        ST_WAIT_FETCH = 3'd3,
        ST_RUN        = 3'd4,
        ST_GATED      = 3'd5
    } state_t;

endpackage

// File: rtl/boot_seq_ctrl_sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches LIMIT.
module sat_counter #(
    parameter int WIDTH = 2,
    parameter int LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != WIDTH'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: programs the FLL, waits for lock, then gates fetch enable
// and core clock gating from the run-control inputs.
//
// state         | meaning
// CFG_REQ       | FLL write k pending, waiting for ack
// CFG_NEXT      | one-cycle request gap, advance k
// LOCK_WAIT     | waiting for FLL lock, bounded by LOCK_TIMEOUT
// WAIT_FETCH    | boot done, waiting for fetch enable
// RUN           | core running, idle detection active
// GATED         | core clock stopped
module boot_seq_ctrl
    import boot_seq_pkg::*;
#(
    parameter int               INIT_WORDS   = 2,
    parameter logic [3:0][31:0] INIT_DATA    = {4{32'h0}},
    parameter int               LOCK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_enable_i,
    output logic                  fll_req_o,
    output logic                  fll_wrn_o,
    output logic [FLL_ADDR_W-1:0] fll_add_o,
    output logic [31:0]           fll_wdata_o,
    input  logic                  fll_ack_i,
    input  logic                  fll_lock_i,
    input  logic                  core_busy_i,
    input  logic                  clk_gate_req_i,
    output logic                  clk_gate_core_o,
    output logic                  fetch_enable_o,
    output logic                  boot_done_o,
    output logic                  lock_timeout_o,
    output logic                  lock_lost_o,
    output logic [2:0]            state_o
);

    localparam int       TMR_W     = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [2:0] WORDS   = 3'(INIT_WORDS);
    localparam logic     HAS_CFG   = (INIT_WORDS > 0);
    localparam state_t   RST_STATE = HAS_CFG ? ST_CFG_REQ : ST_LOCK_WAIT;

    state_t           state;
    logic [2:0]       word_idx;
    logic [2:0]       word_nxt;
    logic [TMR_W-1:0] lock_cnt;
    logic [1:0]       idle_cnt;
    logic             in_lock_wait;
    logic             lock_clr;
    logic             idle_cond;
    logic             idle_clr;
    logic             lock_expired;
    logic             gate_hit;
    logic             post_boot;

    assign word_nxt     = word_idx + 3'd1;
    assign in_lock_wait = (state == ST_LOCK_WAIT);
    assign lock_clr     = ~in_lock_wait;
    assign idle_cond    = clk_gate_req_i & ~core_busy_i;
    assign idle_clr     = (state != ST_RUN) | ~idle_cond;
    assign lock_expired = (lock_cnt == TMR_W'(LOCK_TIMEOUT - 1));
    // idle count is 1 and the condition still holds: it reaches 2 on this edge
    assign gate_hit     = idle_cond & (idle_cnt == 2'd1);
    assign post_boot    = (state == ST_WAIT_FETCH) | (state == ST_RUN) | (state == ST_GATED);

    assign fll_wrn_o      = 1'b0;
    assign state_o        = state;
    assign fetch_enable_o = fetch_enable_i & ((state == ST_RUN) | (state == ST_GATED));

    sat_counter #(
        .WIDTH (TMR_W),
        .LIMIT (LOCK_TIMEOUT - 1)
    ) u_lock_tmr (
        .clk   (clk),
        .rst   (rst),
        .clr   (lock_clr),
        .inc   (in_lock_wait),
        .count (lock_cnt)
    );

    sat_counter #(
        .WIDTH (2),
        .LIMIT (2)
    ) u_idle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (idle_clr),
        .inc   (idle_cond),
        .count (idle_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= RST_STATE;
            word_idx        <= '0;
            fll_req_o       <= HAS_CFG;
            fll_add_o       <= '0;
            // the reset state already presents word 0 alongside the request
            fll_wdata_o     <= HAS_CFG ? INIT_DATA[0] : 32'h0;
            boot_done_o     <= 1'b0;
            lock_timeout_o  <= 1'b0;
            lock_lost_o     <= 1'b0;
            clk_gate_core_o <= 1'b1;
        end else begin
            case (state)
                ST_CFG_REQ: begin
                    if (fll_ack_i) begin
                        state     <= ST_CFG_NEXT;
                        fll_req_o <= 1'b0;
                    end
                end
                ST_CFG_NEXT: begin
                    word_idx <= word_nxt;
                    if (word_nxt == WORDS) begin
                        state <= ST_LOCK_WAIT;
                    end else begin
                        state       <= ST_CFG_REQ;
                        fll_req_o   <= 1'b1;
                        fll_add_o   <= word_nxt[FLL_ADDR_W-1:0];
                        fll_wdata_o <= INIT_DATA[word_nxt[FLL_ADDR_W-1:0]];
                    end
                end
                ST_LOCK_WAIT: begin
                    if (fll_lock_i) begin
                        state       <= ST_WAIT_FETCH;
                        boot_done_o <= 1'b1;
                    end else if (lock_expired) begin
                        state          <= ST_WAIT_FETCH;
                        boot_done_o    <= 1'b1;
                        lock_timeout_o <= 1'b1;
                    end
                end
                ST_WAIT_FETCH: begin
                    if (fetch_enable_i) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!fetch_enable_i) begin
                        state <= ST_WAIT_FETCH;
                    end else if (gate_hit) begin
                        state           <= ST_GATED;
                        clk_gate_core_o <= 1'b0;
                    end
                end
                ST_GATED: begin
                    if (!fetch_enable_i) begin
                        state           <= ST_WAIT_FETCH;
                        clk_gate_core_o <= 1'b1;
                    end else if (!clk_gate_req_i) begin
                        state           <= ST_RUN;
                        clk_gate_core_o <= 1'b1;
                    end
                end
                default: begin
                    state <= RST_STATE;
                end
            endcase

            if (post_boot && !fll_lock_i) begin
                lock_lost_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/boot_seq_ctrl.md
# boot_seq_ctrl

Boot and run-control sequencer sitting between the peripheral-side FLL configuration port and the core-region control inputs. After reset it programs the FLL with a fixed table of configuration words over the req/ack port, waits for FLL lock with a bounded timeout, and then gates `fetch_enable_o` on the external fetch-enable request. In run mode it also sequences core clock gating, so the clock is only stopped when software requests it and the core has been idle for two consecutive cycles.

## Interface
Parameters:
- `INIT_WORDS`, default 2: number of FLL writes issued at boot, range 0..4.
- `INIT_DATA`, default {4{32'h0}}: packed [3:0][31:0]; word k is written to FLL address k.
- `LOCK_TIMEOUT`, default 1024: maximum number of cycles spent in LOCK_WAIT; must be at least 1.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous reset, active-high.
- `fetch_enable_i` in 1: external fetch-enable request.
- `fll_req_o` out 1: FLL configuration request.
- `fll_wrn_o` out 1: 0 = write. Held at 0 because this block only issues writes.
- `fll_add_o` out 2: FLL register address.
- `fll_wdata_o` out 32: FLL write data.
- `fll_ack_i` in 1: FLL acknowledge.
- `fll_lock_i` in 1: FLL lock indication.
- `core_busy_i` in 1: core busy.
- `clk_gate_req_i` in 1: software request to gate the core clock.
- `clk_gate_core_o` out 1: core clock enable; 1 = running.
- `fetch_enable_o` out 1: core fetch enable.
- `boot_done_o` out 1: high from WAIT_FETCH onward.
- `lock_timeout_o` out 1: sticky; lock not reached within `LOCK_TIMEOUT`.
- `lock_lost_o` out 1: sticky; lock dropped after boot.
- `state_o` out 3: current state encoding, for debug.

## Operation
States and transitions:
- CFG_REQ: drive `fll_req_o`=1, `fll_add_o`=k, `fll_wdata_o`=`INIT_DATA[k]`.
  - On `fll_ack_i`=1, go to CFG_NEXT.
  - Address and data stay stable while the request is pending.
- CFG_NEXT: `fll_req_o`=0 for exactly one cycle, then k++.
  - If k==`INIT_WORDS`, go to LOCK_WAIT; otherwise go to CFG_REQ.
- Reset exit: state after reset is CFG_REQ with k=0. If `INIT_WORDS`==0, the state after reset is LOCK_WAIT instead.
- LOCK_WAIT: counter counts up from 0.
  - `fll_lock_i`=1 → WAIT_FETCH.
  - Counter reaches `LOCK_TIMEOUT`-1 with no lock → set `lock_timeout_o`, go to WAIT_FETCH (fallback boot).
  - If lock arrives on the timeout cycle, lock wins and no flag is set.
- WAIT_FETCH: `fetch_enable_i`=1 → RUN.
- RUN: `fetch_enable_o`=`fetch_enable_i`.
  - `fetch_enable_i`=0 → WAIT_FETCH.
  - Idle counter (2-bit, saturating) increments while `clk_gate_req_i` & !`core_busy_i` holds, and clears otherwise.
  - When the idle counter reaches 2 → GATED.
- GATED: `clk_gate_core_o`=0, `fetch_enable_o`=`fetch_enable_i`.
  - `clk_gate_req_i`=0 → RUN.
  - `fetch_enable_i`=0 → WAIT_FETCH, with the clock enabled.
- Lock monitoring: in WAIT_FETCH, RUN and GATED, `fll_lock_i`=0 sets `lock_lost_o`. No state change.
- Ack handling: `fll_ack_i` is ignored outside CFG_REQ.
- Reset values: `fll_req_o` = 1 after reset when `INIT_WORDS`>0 (it is a registered output of CFG_REQ), otherwise 0. All other outputs reset to 0, except `clk_gate_core_o`=1.

## Timing
- Outputs: all outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs, except `fetch_enable_o`, which is combinational from `fetch_enable_i` in RUN/GATED.
- FLL write latency: ack in cycle n → `fll_req_o` low in n+1 → next request in n+2.
- Lock latency: lock seen in cycle n → `boot_done_o` high in n+1.
- Gate latency: gate condition true in cycles n and n+1 → `clk_gate_core_o`=0 from n+2.
- Wake latency: `clk_gate_req_i` low in cycle n → `clk_gate_core_o`=1 in n+1.
- Reset mid-operation: asynchronous; returns immediately to the reset state and reset values. Sticky flags clear only on reset.
- Simultaneous events in RUN: `fetch_enable_i` drop takes priority over the gate transition.

## Structure
- `boot_seq_pkg` holds:
  - the state enum (3 bits);
  - the FLL address width constant (2).
- One sub-module: `sat_counter` (parameterised width and saturation limit), instanced for the lock-timeout counter and the idle counter.

## Test plan
- Normal boot: `INIT_WORDS`=2, ack returned 3 cycles after each req, lock 10 cycles later, then `fetch_enable_i`=1.
  - Expect writes to addr 0 and 1 with `INIT_DATA`, req low for exactly 1 cycle between them.
  - Expect `boot_done_o`, then `fetch_enable_o`=1.
- Lock timeout: `LOCK_TIMEOUT`=16, lock never asserted → `lock_timeout_o`=1 and WAIT_FETCH exactly 16 cycles after entering LOCK_WAIT.
- Clock gating: in RUN, `clk_gate_req_i`=1 with `core_busy_i` toggling every cycle → no gating. Then `core_busy_i`=0 held → `clk_gate_core_o`=0 after 2 cycles. Drop `clk_gate_req_i` → 1 next cycle.
- Lock loss: lock drops for 1 cycle in RUN → `lock_lost_o` sticky, `fetch_enable_o` unaffected.
- Reset during CFG_REQ with ack pending → all outputs return to reset values; write sequence restarts at addr 0.
- `INIT_WORDS`=0 → no `fll_req_o` ever; LOCK_WAIT is entered on the first cycle after reset.
